// File: rtl/cpu_axi_arbiter.sv
// Two-master AXI3 arbiter: s0 = ifetch, s1 = data; whole-burst read and write grants.
// Define CPU_ARB_RR_EN for round-robin; otherwise s1 wins ties.
module cpu_axi_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ID_W-1:0]   s0_arid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [3:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic [1:0]        s0_arlock,
  input  logic [3:0]        s0_arcache,
  input  logic [2:0]        s0_arprot,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [ID_W-1:0]   s0_rid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ID_W-1:0]   s0_awid,
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic [3:0]        s0_awlen,
  input  logic [2:0]        s0_awsize,
  input  logic [1:0]        s0_awburst,
  input  logic [1:0]        s0_awlock,
  input  logic [3:0]        s0_awcache,
  input  logic [2:0]        s0_awprot,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [STRB_W-1:0] s0_wstrb,
  input  logic              s0_wlast,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  output logic [ID_W-1:0]   s0_bid,
  output logic [1:0]        s0_bresp,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  input  logic [ID_W-1:0]   s1_arid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [3:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic [1:0]        s1_arlock,
  input  logic [3:0]        s1_arcache,
  input  logic [2:0]        s1_arprot,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [ID_W-1:0]   s1_rid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  input  logic [ID_W-1:0]   s1_awid,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic [3:0]        s1_awlen,
  input  logic [2:0]        s1_awsize,
  input  logic [1:0]        s1_awburst,
  input  logic [1:0]        s1_awlock,
  input  logic [3:0]        s1_awcache,
  input  logic [2:0]        s1_awprot,
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [STRB_W-1:0] s1_wstrb,
  input  logic              s1_wlast,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  output logic [ID_W-1:0]   s1_bid,
  output logic [1:0]        s1_bresp,
  output logic              s1_bvalid,
  input  logic              s1_bready,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [3:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [1:0]        m_arlock,
  output logic [3:0]        m_arcache,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ID_W-1:0]   m_awid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [3:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic [1:0]        m_awlock,
  output logic [3:0]        m_awcache,
  output logic [2:0]        m_awprot,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [ID_W-1:0]   m_bid,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;

  r_state_t r_state;
  w_state_t w_state;
  logic     r_gnt;
  logic     w_gnt;
  logic     r_pick;
  logic     w_pick;
  logic     aw_done;
  logic     w_done;
  logic     r_end;
  logic     aw_hs;
  logic     w_end;
  logic     b_hs;
  logic     w_fwd;

`ifdef CPU_ARB_RR_EN
  logic r_ptr;
  logic w_ptr;

  always_comb begin
    r_pick = (s0_arvalid && s1_arvalid) ? r_ptr : s1_arvalid;
    w_pick = (s0_awvalid && s1_awvalid) ? w_ptr : s1_awvalid;
  end
`else
  always_comb begin
    r_pick = s1_arvalid;
    w_pick = s1_awvalid;
  end
`endif

  assign r_end = m_rvalid && m_rready && m_rlast;
  assign aw_hs = m_awvalid && m_awready;
  assign w_end = m_wvalid && m_wready && m_wlast;
  assign b_hs  = m_bvalid && m_bready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= R_IDLE;
      r_gnt     <= 1'b0;
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      m_arlock  <= '0;
      m_arcache <= '0;
      m_arprot  <= '0;
`ifdef CPU_ARB_RR_EN
      r_ptr     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        R_IDLE: if (s0_arvalid || s1_arvalid) begin
          r_gnt     <= r_pick;
          m_arvalid <= 1'b1;
          m_arid    <= r_pick ? s1_arid    : s0_arid;
          m_araddr  <= r_pick ? s1_araddr  : s0_araddr;
          m_arlen   <= r_pick ? s1_arlen   : s0_arlen;
          m_arsize  <= r_pick ? s1_arsize  : s0_arsize;
          m_arburst <= r_pick ? s1_arburst : s0_arburst;
          m_arlock  <= r_pick ? s1_arlock  : s0_arlock;
          m_arcache <= r_pick ? s1_arcache : s0_arcache;
          m_arprot  <= r_pick ? s1_arprot  : s0_arprot;
          r_state   <= R_ADDR;
        end
        R_ADDR: if (m_arready) begin
          m_arvalid <= 1'b0;
          r_state   <= R_DATA;
        end
        R_DATA: if (r_end) begin
`ifdef CPU_ARB_RR_EN
          r_ptr   <= ~r_gnt;
`endif
          r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // AW and W may complete in either order; W_RESP needs both.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state   <= W_IDLE;
      w_gnt     <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      m_awvalid <= 1'b0;
      m_awid    <= '0;
      m_awaddr  <= '0;
      m_awlen   <= '0;
      m_awsize  <= '0;
      m_awburst <= '0;
      m_awlock  <= '0;
      m_awcache <= '0;
      m_awprot  <= '0;
`ifdef CPU_ARB_RR_EN
      w_ptr     <= 1'b0;
`endif
    end else begin
      unique case (w_state)
        W_IDLE: if (s0_awvalid || s1_awvalid) begin
          w_gnt     <= w_pick;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          m_awvalid <= 1'b1;
          m_awid    <= w_pick ? s1_awid    : s0_awid;
          m_awaddr  <= w_pick ? s1_awaddr  : s0_awaddr;
          m_awlen   <= w_pick ? s1_awlen   : s0_awlen;
          m_awsize  <= w_pick ? s1_awsize  : s0_awsize;
          m_awburst <= w_pick ? s1_awburst : s0_awburst;
          m_awlock  <= w_pick ? s1_awlock  : s0_awlock;
          m_awcache <= w_pick ? s1_awcache : s0_awcache;
          m_awprot  <= w_pick ? s1_awprot  : s0_awprot;
          w_state   <= W_ADDR;
        end
        W_ADDR: begin
          if (aw_hs) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_end) w_done <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_end))
            w_state <= W_RESP;
        end
        W_RESP: if (b_hs) begin
`ifdef CPU_ARB_RR_EN
          w_ptr   <= ~w_gnt;
`endif
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign s0_arready = (r_state == R_ADDR) && !r_gnt && m_arready;
  assign s1_arready = (r_state == R_ADDR) &&  r_gnt && m_arready;

  assign s0_rvalid = (r_state == R_DATA) && !r_gnt && m_rvalid;
  assign s1_rvalid = (r_state == R_DATA) &&  r_gnt && m_rvalid;
  assign m_rready  = (r_state == R_DATA) && (r_gnt ? s1_rready : s0_rready);
  assign s0_rid    = m_rid;
  assign s0_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rid    = m_rid;
  assign s1_rdata  = m_rdata;
  assign s1_rresp  = m_rresp;
  assign s1_rlast  = m_rlast;

  assign s0_awready = m_awvalid && !w_gnt && m_awready;
  assign s1_awready = m_awvalid &&  w_gnt && m_awready;

  assign w_fwd     = (w_state == W_ADDR) && !w_done;
  assign m_wvalid  = w_fwd && (w_gnt ? s1_wvalid : s0_wvalid);
  assign m_wdata   = w_gnt ? s1_wdata : s0_wdata;
  assign m_wstrb   = w_gnt ? s1_wstrb : s0_wstrb;
  assign m_wlast   = w_gnt ? s1_wlast : s0_wlast;
  assign s0_wready = w_fwd && !w_gnt && m_wready;
  assign s1_wready = w_fwd &&  w_gnt && m_wready;

  assign s0_bvalid = (w_state == W_RESP) && !w_gnt && m_bvalid;
  assign s1_bvalid = (w_state == W_RESP) &&  w_gnt && m_bvalid;
  assign m_bready  = (w_state == W_RESP) && (w_gnt ? s1_bready : s0_bready);
  assign s0_bid    = m_bid;
  assign s0_bresp  = m_bresp;
  assign s1_bid    = m_bid;
  assign s1_bresp  = m_bresp;

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// Directed-vector bench for cpu_axi_arbiter.
// Expected first winner of a tie follows CPU_ARB_RR_EN.
module tb_cpu_axi_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  s0_arid, s1_arid, s0_awid, s1_awid;
  logic [31:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr;
  logic [3:0]  s0_arlen, s1_arlen, s0_awlen, s1_awlen;
  logic [2:0]  s0_arsize, s1_arsize, s0_awsize, s1_awsize;
  logic [1:0]  s0_arburst, s1_arburst, s0_awburst, s1_awburst;
  logic [1:0]  s0_arlock, s1_arlock, s0_awlock, s1_awlock;
  logic [3:0]  s0_arcache, s1_arcache, s0_awcache, s1_awcache;
  logic [2:0]  s0_arprot, s1_arprot, s0_awprot, s1_awprot;
  logic        s0_arvalid, s1_arvalid, s0_awvalid, s1_awvalid;
  logic        s0_arready, s1_arready, s0_awready, s1_awready;
  logic [3:0]  s0_rid, s1_rid, s0_bid, s1_bid;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rresp, s1_rresp, s0_bresp, s1_bresp;
  logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
  logic        s0_rready, s1_rready;
  logic [31:0] s0_wdata, s1_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic        s0_wlast, s1_wlast, s0_wvalid, s1_wvalid;
  logic        s0_wready, s1_wready;
  logic        s0_bvalid, s1_bvalid, s0_bready, s1_bready;
  logic [3:0]  m_arid, m_awid, m_rid, m_bid;
  logic [31:0] m_araddr, m_awaddr;
  logic [3:0]  m_arlen, m_awlen, m_arcache, m_awcache;
  logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
  logic [1:0]  m_arburst, m_awburst, m_arlock, m_awlock;
  logic        m_arvalid, m_arready, m_awvalid, m_awready;
  logic [31:0] m_rdata, m_wdata;
  logic [1:0]  m_rresp, m_bresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready;

  int tests = 0;
  int fails = 0;

`ifdef CPU_ARB_RR_EN
  localparam bit FIRST = 1'b0;
`else
  localparam bit FIRST = 1'b1;
`endif

  logic [14:0] ctl;
  assign ctl = {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                s0_arready, s1_arready, s0_awready, s1_awready,
                s0_wready, s1_wready, s0_rvalid, s1_rvalid,
                s0_bvalid, s1_bvalid};

  always #5 aclk = ~aclk;

  cpu_axi_arbiter dut (
    .aclk(aclk), .areset(areset),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arlock(s0_arlock),
    .s0_arcache(s0_arcache), .s0_arprot(s0_arprot),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen),
    .s0_awsize(s0_awsize), .s0_awburst(s0_awburst), .s0_awlock(s0_awlock),
    .s0_awcache(s0_awcache), .s0_awprot(s0_awprot),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid),
    .s0_bready(s0_bready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arlock(s1_arlock),
    .s1_arcache(s1_arcache), .s1_arprot(s1_arprot),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen),
    .s1_awsize(s1_awsize), .s1_awburst(s1_awburst), .s1_awlock(s1_awlock),
    .s1_awcache(s1_awcache), .s1_awprot(s1_awprot),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid),
    .s1_bready(s1_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock),
    .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    {s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst} = '0;
    {s0_arlock, s0_arcache, s0_arprot, s0_arvalid} = '0;
    {s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst} = '0;
    {s1_arlock, s1_arcache, s1_arprot, s1_arvalid} = '0;
    {s0_awid, s0_awaddr, s0_awlen, s0_awsize, s0_awburst} = '0;
    {s0_awlock, s0_awcache, s0_awprot, s0_awvalid} = '0;
    {s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst} = '0;
    {s1_awlock, s1_awcache, s1_awprot, s1_awvalid} = '0;
    {s0_wdata, s0_wstrb, s0_wlast, s0_wvalid} = '0;
    {s1_wdata, s1_wstrb, s1_wlast, s1_wvalid} = '0;
    {s0_rready, s1_rready, s0_bready, s1_bready} = '0;
    {m_arready, m_awready, m_wready} = '0;
    {m_rid, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;
    {m_bid, m_bresp, m_bvalid} = '0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_inputs();
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    clear_inputs();
    s0_rready = 1'b1;
    s1_bready = 1'b1;
    #1;
    tests++;
    if (ctl !== 15'd0) begin
      fails++;
      $display("FAIL reset_ctl got %b exp 0", ctl);
    end
    tick();
    tests++;
    if (m_araddr !== 32'd0 || m_arlen !== 4'd0) begin
      fails++;
      $display("FAIL reset_ar got %h/%h exp 0", m_araddr, m_arlen);
    end
    areset = 1'b0;
    tick();
    tests++;
    if (ctl !== 15'd0) begin
      fails++;
      $display("FAIL idle_ctl got %b exp 0", ctl);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    s0_arvalid = 1'b1;
    s0_araddr = 32'h1FC0_0000;
    s0_arlen = 4'd3;
    s0_arid = 4'h6;
    #1;
    tests++;
    if (m_arvalid !== 1'b0) begin
      fails++;
      $display("FAIL rd_arvalid_early got %b exp 0", m_arvalid);
    end
    tick();
    tests++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h1FC0_0000 ||
        m_arlen !== 4'd3 || m_arid !== 4'h6) begin
      fails++;
      $display("FAIL rd_ar got v%b a%h l%h i%h exp v1 a1fc00000 l3 i6",
               m_arvalid, m_araddr, m_arlen, m_arid);
    end
    m_arready = 1'b1;
    #1;
    tests++;
    if (s0_arready !== 1'b1 || s1_arready !== 1'b0) begin
      fails++;
      $display("FAIL rd_arready got %b%b exp 10", s0_arready, s1_arready);
    end
    tick();
    s0_arvalid = 1'b0;
    m_arready = 1'b0;
    s0_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1;
      m_rdata = 32'hD000_0000 + 32'(i);
      m_rlast = (i == 3);
      #1;
      tests++;
      if (s0_rvalid !== 1'b1 || s1_rvalid !== 1'b0 || m_rready !== 1'b1 ||
          s0_rdata !== 32'hD000_0000 + 32'(i) || m_arvalid !== 1'b0) begin
        fails++;
        $display("FAIL rd_beat%0d got v%b%b rdy%b d%h exp v10 rdy1 d%h",
                 i, s0_rvalid, s1_rvalid, m_rready, s0_rdata,
                 32'hD000_0000 + 32'(i));
      end
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    #1;
    tests++;
    if (m_rready !== 1'b0) begin
      fails++;
      $display("FAIL rd_end_rready got %b exp 0", m_rready);
    end
  endtask

  task automatic test_tie();
    logic [31:0] a_first;
    logic [31:0] a_second;
    do_reset();
    a_first = FIRST ? 32'h200 : 32'h100;
    a_second = FIRST ? 32'h100 : 32'h200;
    s0_arvalid = 1'b1;
    s0_araddr = 32'h100;
    s1_arvalid = 1'b1;
    s1_araddr = 32'h200;
    tick();
    tests++;
    if (m_arvalid !== 1'b1 || m_araddr !== a_first) begin
      fails++;
      $display("FAIL tie_first got %b/%h exp 1/%h", m_arvalid, m_araddr, a_first);
    end
    m_arready = 1'b1;
    #1;
    tests++;
    if ({s0_arready, s1_arready} !== (FIRST ? 2'b01 : 2'b10)) begin
      fails++;
      $display("FAIL tie_arready got %b%b exp first=s%0d",
               s0_arready, s1_arready, FIRST);
    end
    tick();
    m_arready = 1'b0;
    if (FIRST) s1_arvalid = 1'b0;
    else s0_arvalid = 1'b0;
    {s0_rready, s1_rready} = 2'b11;
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    #1;
    tests++;
    if ({s0_rvalid, s1_rvalid} !== (FIRST ? 2'b01 : 2'b10) ||
        s0_arready !== 1'b0 || s1_arready !== 1'b0) begin
      fails++;
      $display("FAIL tie_route got r%b%b ar%b%b", s0_rvalid, s1_rvalid,
               s0_arready, s1_arready);
    end
    tick();
    m_rvalid = 1'b0;
    #1;
    tests++;
    if (m_arvalid !== 1'b0) begin
      fails++;
      $display("FAIL tie_gap got %b exp 0", m_arvalid);
    end
    tick();
    tests++;
    if (m_arvalid !== 1'b1 || m_araddr !== a_second) begin
      fails++;
      $display("FAIL tie_second got %b/%h exp 1/%h", m_arvalid, m_araddr, a_second);
    end
    m_arready = 1'b1;
    tick();
    {s0_arvalid, s1_arvalid, m_arready} = '0;
    m_rvalid = 1'b1;
    #1;
    tests++;
    if ({s0_rvalid, s1_rvalid} !== (FIRST ? 2'b10 : 2'b01)) begin
      fails++;
      $display("FAIL tie_route2 got %b%b", s0_rvalid, s1_rvalid);
    end
    tick();
    {m_rvalid, m_rlast} = '0;
  endtask

  task automatic test_write_early_w();
    do_reset();
    s1_awvalid = 1'b1;
    s1_awaddr = 32'h3000;
    s1_awlen = 4'd0;
    s1_wvalid = 1'b1;
    s1_wdata = 32'hCAFE_0001;
    s1_wstrb = 4'hF;
    s1_wlast = 1'b1;
    m_wready = 1'b1;
    tick();
    tests++;
    if (m_awvalid !== 1'b1 || m_awaddr !== 32'h3000 || m_wvalid !== 1'b1 ||
        m_wdata !== 32'hCAFE_0001 || s1_wready !== 1'b1 || s0_wready !== 1'b0) begin
      fails++;
      $display("FAIL wr_w_fwd got aw%b a%h w%b d%h rdy%b%b",
               m_awvalid, m_awaddr, m_wvalid, m_wdata, s0_wready, s1_wready);
    end
    tick();
    s1_wvalid = 1'b0;
    s1_bready = 1'b1;
    #1;
    tests++;
    if (m_wvalid !== 1'b0 || m_awvalid !== 1'b1 || m_bready !== 1'b0) begin
      fails++;
      $display("FAIL wr_wait_aw got w%b aw%b b%b exp 0 1 0",
               m_wvalid, m_awvalid, m_bready);
    end
    tick();
    m_awready = 1'b1;
    #1;
    tests++;
    if (s1_awready !== 1'b1 || s0_awready !== 1'b0 || m_bready !== 1'b0) begin
      fails++;
      $display("FAIL wr_awready got %b%b b%b exp 01 0",
               s0_awready, s1_awready, m_bready);
    end
    tick();
    s1_awvalid = 1'b0;
    m_awready = 1'b0;
    m_bvalid = 1'b1;
    m_bresp = 2'b10;
    m_bid = 4'h5;
    #1;
    tests++;
    if (m_awvalid !== 1'b0 || s1_bvalid !== 1'b1 || s0_bvalid !== 1'b0 ||
        s1_bresp !== 2'b10 || s1_bid !== 4'h5 || m_bready !== 1'b1) begin
      fails++;
      $display("FAIL wr_resp got aw%b b%b%b r%b i%h rdy%b exp 0 01 10 5 1",
               m_awvalid, s0_bvalid, s1_bvalid, s1_bresp, s1_bid, m_bready);
    end
    tick();
    m_bvalid = 1'b0;
    #1;
    tests++;
    if (m_bready !== 1'b0 || s1_bvalid !== 1'b0) begin
      fails++;
      $display("FAIL wr_done got %b%b exp 00", m_bready, s1_bvalid);
    end
  endtask

  task automatic test_concurrent();
    do_reset();
    s0_arvalid = 1'b1;
    s0_araddr = 32'h8000;
    s0_arlen = 4'd7;
    s1_awvalid = 1'b1;
    s1_awaddr = 32'h9000;
    s1_awlen = 4'd1;
    s1_wvalid = 1'b1;
    s1_wdata = 32'h11;
    s1_wlast = 1'b0;
    {m_arready, m_awready, m_wready} = 3'b111;
    tick();
    tests++;
    if (s0_arready !== 1'b1 || s1_awready !== 1'b1 ||
        m_wvalid !== 1'b1 || m_wlast !== 1'b0) begin
      fails++;
      $display("FAIL cc_addr got ar%b aw%b w%b l%b",
               s0_arready, s1_awready, m_wvalid, m_wlast);
    end
    tick();
    s0_arvalid = 1'b0;
    s1_awvalid = 1'b0;
    s0_rready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m_rvalid = 1'b1;
      m_rdata = 32'hA0 + 32'(i);
      m_rlast = (i == 7);
      if (i == 0) begin
        s1_wdata = 32'h22;
        s1_wlast = 1'b1;
      end
      if (i == 1) begin
        s1_wvalid = 1'b0;
        m_bvalid = 1'b1;
        m_bid = 4'h3;
        s1_bready = 1'b1;
      end
      if (i == 2) m_bvalid = 1'b0;
      #1;
      tests++;
      if (s0_rvalid !== 1'b1 || s1_rvalid !== 1'b0 ||
          s0_rdata !== 32'hA0 + 32'(i) || s0_bvalid !== 1'b0) begin
        fails++;
        $display("FAIL cc_r%0d got r%b%b d%h b0%b", i,
                 s0_rvalid, s1_rvalid, s0_rdata, s0_bvalid);
      end
      if (i == 0) begin
        tests++;
        if (m_wlast !== 1'b1 || s1_wready !== 1'b1 || m_wdata !== 32'h22) begin
          fails++;
          $display("FAIL cc_wlast got l%b r%b d%h", m_wlast, s1_wready, m_wdata);
        end
      end
      if (i == 1) begin
        tests++;
        if (s1_bvalid !== 1'b1 || s1_bid !== 4'h3 || m_bready !== 1'b1) begin
          fails++;
          $display("FAIL cc_b got v%b i%h r%b", s1_bvalid, s1_bid, m_bready);
        end
      end
      if (i == 2) begin
        tests++;
        if (m_bready !== 1'b0) begin
          fails++;
          $display("FAIL cc_widle got %b exp 0", m_bready);
        end
      end
      tick();
    end
    {m_rvalid, m_rlast} = '0;
    #1;
    tests++;
    if (m_rready !== 1'b0) begin
      fails++;
      $display("FAIL cc_rend got %b exp 0", m_rready);
    end
    {m_arready, m_awready, m_wready, s1_bready} = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    s0_arvalid = 1'b1;
    s0_araddr = 32'h7000;
    s0_arlen = 4'd3;
    m_arready = 1'b1;
    tick();
    tick();
    s0_arvalid = 1'b0;
    m_arready = 1'b0;
    s0_rready = 1'b1;
    m_rvalid = 1'b1;
    m_rdata = 32'hB0;
    tick();
    m_rdata = 32'hB1;
    s0_rready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (m_rready !== 1'b0 || s0_rvalid !== 1'b1 || s0_rdata !== 32'hB1) begin
        fails++;
        $display("FAIL bp_stall%0d got rdy%b v%b d%h", k,
                 m_rready, s0_rvalid, s0_rdata);
      end
      tick();
    end
    s0_rready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      m_rdata = 32'hB0 + 32'(i);
      m_rlast = (i == 3);
      #1;
      tests++;
      if (m_rready !== 1'b1 || s0_rvalid !== 1'b1) begin
        fails++;
        $display("FAIL bp_beat%0d got rdy%b v%b", i, m_rready, s0_rvalid);
      end
      tick();
    end
    {m_rvalid, m_rlast} = '0;
    #1;
    tests++;
    if (m_rready !== 1'b0) begin
      fails++;
      $display("FAIL bp_end got %b exp 0", m_rready);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    s0_arvalid = 1'b1;
    s0_araddr = 32'h5000;
    s0_arlen = 4'd3;
    m_arready = 1'b1;
    tick();
    tick();
    s0_arvalid = 1'b0;
    m_arready = 1'b0;
    s0_rready = 1'b1;
    m_rvalid = 1'b1;
    tick();
    tick();
    #1;
    tests++;
    if (s0_rvalid !== 1'b1) begin
      fails++;
      $display("FAIL rm_beat2 got %b exp 1", s0_rvalid);
    end
    areset = 1'b1;
    #1;
    tests++;
    if (ctl !== 15'd0) begin
      fails++;
      $display("FAIL rm_async got %b exp 0", ctl);
    end
    tick();
    tests++;
    if (ctl !== 15'd0) begin
      fails++;
      $display("FAIL rm_next got %b exp 0", ctl);
    end
    areset = 1'b0;
    m_rvalid = 1'b0;
    s1_arvalid = 1'b1;
    s1_araddr = 32'h6000;
    s1_arlen = 4'd0;
    tick();
    tests++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h6000) begin
      fails++;
      $display("FAIL rm_newar got %b/%h exp 1/6000", m_arvalid, m_araddr);
    end
    m_arready = 1'b1;
    tick();
    s1_arvalid = 1'b0;
    m_arready = 1'b0;
    s1_rready = 1'b1;
    m_rvalid = 1'b1;
    m_rlast = 1'b1;
    #1;
    tests++;
    if (s1_rvalid !== 1'b1 || s0_rvalid !== 1'b0 || m_rready !== 1'b1) begin
      fails++;
      $display("FAIL rm_newr got %b%b rdy%b exp 01 1",
               s0_rvalid, s1_rvalid, m_rready);
    end
    tick();
    {m_rvalid, m_rlast} = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_write_early_w();
    test_concurrent();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
